// File: rtl/message_lane_sched.sv
// Three-lane message batcher: collects up to three messages, then
// presents them together with message_en held for HOLD_CYC cycles.
module message_lane_sched #(
   parameter int MSG_W       = 256,
   parameter int CTRL_W      = 4,
   parameter int MUX_DEFAULT = 0,
   parameter int TMO         = 8,
   parameter int HOLD_CYC    = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [MSG_W-1:0]  in_message,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              message_en,
   output logic [MSG_W-1:0]  message_1,
   output logic [MSG_W-1:0]  message_2,
   output logic [MSG_W-1:0]  message_3,
   output logic [CTRL_W-1:0] message_mux_control_m1,
   output logic [CTRL_W-1:0] message_mux_control_m2,
   output logic [CTRL_W-1:0] message_mux_control_m3,
   output logic              batch_done,
   output logic [1:0]        batch_cnt,
   output logic              ctrl_err
);

   typedef enum logic [1:0] {IDLE, COLLECT, ISSUE} state_t;

   localparam logic [CTRL_W-1:0] DEF       = CTRL_W'(MUX_DEFAULT);
   localparam logic [7:0]        TMO_LAST  = 8'(TMO - 1);
   localparam logic [7:0]        HOLD_LAST = 8'(HOLD_CYC - 1);

   state_t            state_q, state_d;
   logic [7:0]        tmr_q, tmr_d;
   logic [7:0]        hold_q, hold_d;
   logic [1:0]        cnt_q, cnt_d;
   logic              en_q, en_d;
   logic              done_q, done_d;
   logic              err_q, err_d;
   logic [MSG_W-1:0]  msg_q [3];
   logic [MSG_W-1:0]  msg_d [3];
   logic [CTRL_W-1:0] ctl_q [3];
   logic [CTRL_W-1:0] ctl_d [3];
   logic              xfer, load;

   assign in_ready = (state_q != ISSUE);
   assign xfer     = in_valid && in_ready;
   assign load     = xfer && (in_ctrl != DEF);

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      hold_d  = hold_q;
      cnt_d   = cnt_q;
      en_d    = en_q;
      done_d  = 1'b0;
      err_d   = xfer && (in_ctrl == DEF);
      for (int i = 0; i < 3; i++) begin
         msg_d[i] = msg_q[i];
         ctl_d[i] = ctl_q[i];
      end
      unique case (state_q)
         IDLE: begin
            if (load) begin
               msg_d[0] = in_message;
               ctl_d[0] = in_ctrl;
               cnt_d    = 2'd1;
               tmr_d    = 8'd0;
               state_d  = COLLECT;
            end
         end
         COLLECT: begin
            tmr_d = tmr_q + 8'd1;
            if (load) begin
               for (int i = 0; i < 3; i++) begin
                  if (cnt_q == 2'(i)) begin
                     msg_d[i] = in_message;
                     ctl_d[i] = in_ctrl;
                  end
               end
               cnt_d = cnt_q + 2'd1;
            end
            // A load on the timeout cycle still rides in this batch.
            if ((load && cnt_q == 2'd2) || tmr_q == TMO_LAST) begin
               state_d = ISSUE;
               en_d    = 1'b1;
               hold_d  = 8'd0;
               tmr_d   = 8'd0;
               done_d  = (HOLD_LAST == 8'd0);
            end
         end
         ISSUE: begin
            if (hold_q == HOLD_LAST) begin
               state_d = IDLE;
               en_d    = 1'b0;
               cnt_d   = 2'd0;
               hold_d  = 8'd0;
               for (int i = 0; i < 3; i++) begin
                  msg_d[i] = '0;
                  ctl_d[i] = DEF;
               end
            end else begin
               hold_d = hold_q + 8'd1;
               done_d = (hold_q + 8'd1 == HOLD_LAST);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         tmr_q   <= 8'd0;
         hold_q  <= 8'd0;
         cnt_q   <= 2'd0;
         en_q    <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         for (int i = 0; i < 3; i++) begin
            msg_q[i] <= '0;
            ctl_q[i] <= DEF;
         end
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
         hold_q  <= hold_d;
         cnt_q   <= cnt_d;
         en_q    <= en_d;
         done_q  <= done_d;
         err_q   <= err_d;
         for (int i = 0; i < 3; i++) begin
            msg_q[i] <= msg_d[i];
            ctl_q[i] <= ctl_d[i];
         end
      end
   end

   assign message_en             = en_q;
   assign batch_done             = done_q;
   assign batch_cnt              = cnt_q;
   assign ctrl_err               = err_q;
   assign message_1              = msg_q[0];
   assign message_2              = msg_q[1];
   assign message_3              = msg_q[2];
   assign message_mux_control_m1 = ctl_q[0];
   assign message_mux_control_m2 = ctl_q[1];
   assign message_mux_control_m3 = ctl_q[2];

endmodule

// File: tb/tb_message_lane_sched.sv
// Directed bench for message_lane_sched: full batch, timeout,
// timeout collision, default control, backpressure, reset mid-issue.
module tb_message_lane_sched;

   localparam int MSG_W  = 256;
   localparam int CTRL_W = 4;
   localparam int HOLD   = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              in_valid;
   logic              in_ready;
   logic [MSG_W-1:0]  in_message;
   logic [CTRL_W-1:0] in_ctrl;
   logic              message_en;
   logic [MSG_W-1:0]  message_1, message_2, message_3;
   logic [CTRL_W-1:0] m1, m2, m3;
   logic              batch_done;
   logic [1:0]        batch_cnt;
   logic              ctrl_err;

   int n_chk  = 0;
   int n_pass = 0;

   message_lane_sched #(
      .MSG_W(MSG_W), .CTRL_W(CTRL_W), .MUX_DEFAULT(0),
      .TMO(8), .HOLD_CYC(HOLD)
   ) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_message(in_message), .in_ctrl(in_ctrl),
      .message_en(message_en),
      .message_1(message_1), .message_2(message_2),
      .message_3(message_3),
      .message_mux_control_m1(m1),
      .message_mux_control_m2(m2),
      .message_mux_control_m3(m3),
      .batch_done(batch_done), .batch_cnt(batch_cnt),
      .ctrl_err(ctrl_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [MSG_W-1:0] obs,
                      input logic [MSG_W-1:0] exp);
      n_chk++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [CTRL_W-1:0] c,
                       input logic [MSG_W-1:0] d);
      in_valid   = 1'b1;
      in_ctrl    = c;
      in_message = d;
      step();
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".en"},    message_en, 0);
      chk({tag, ".done"},  batch_done, 0);
      chk({tag, ".cnt"},   batch_cnt, 0);
      chk({tag, ".rdy"},   in_ready, 1);
      chk({tag, ".m1"},    m1, 0);
      chk({tag, ".m2"},    m2, 0);
      chk({tag, ".m3"},    m3, 0);
      chk({tag, ".msg1"},  message_1, 0);
      chk({tag, ".msg3"},  message_3, 0);
   endtask

   // Called in the first ISSUE cycle; ends in the first IDLE cycle.
   task automatic finish_issue(input string tag,
                               input logic [1:0] cnt);
      for (int i = 1; i < HOLD; i++) begin
         step();
         chk({tag, ".en"},   message_en, 1);
         chk({tag, ".done"}, batch_done, (i == HOLD - 1));
         chk({tag, ".hcnt"}, batch_cnt, cnt);
         chk({tag, ".hrdy"}, in_ready, 0);
      end
      step();
      chk_idle({tag, ".end"});
   endtask

   initial begin
      rst        = 1'b1;
      in_valid   = 1'b1;
      in_ctrl    = 4'd1;
      in_message = 256'h77;
      repeat (3) step();
      chk_idle("reset");
      in_valid = 1'b0;
      rst      = 1'b0;
      step();
      chk_idle("post_reset");

      // Full batch
      send(4'd1, 256'hA1);
      chk("full.c1", batch_cnt, 1);
      chk("full.en0", message_en, 0);
      send(4'd2, 256'hB2);
      chk("full.c2", batch_cnt, 2);
      send(4'd3, 256'hC3);
      in_valid = 1'b0;
      chk("full.en", message_en, 1);
      chk("full.done0", batch_done, 0);
      chk("full.cnt", batch_cnt, 3);
      chk("full.m1", m1, 1);
      chk("full.m2", m2, 2);
      chk("full.m3", m3, 3);
      chk("full.msg1", message_1, 256'hA1);
      chk("full.msg2", message_2, 256'hB2);
      chk("full.msg3", message_3, 256'hC3);
      chk("full.rdy", in_ready, 0);
      finish_issue("full", 2'd3);

      // Timeout with a single message
      send(4'd5, 256'hD5);
      in_valid = 1'b0;
      repeat (7) step();
      chk("tmo.en_early", message_en, 0);
      chk("tmo.rdy_early", in_ready, 1);
      step();
      chk("tmo.en", message_en, 1);
      chk("tmo.cnt", batch_cnt, 1);
      chk("tmo.m1", m1, 5);
      chk("tmo.m2", m2, 0);
      chk("tmo.m3", m3, 0);
      chk("tmo.msg2", message_2, 0);
      finish_issue("tmo", 2'd1);

      // Second transfer on the timeout cycle
      send(4'd1, 256'hE1);
      in_valid = 1'b0;
      repeat (7) step();
      chk("col.en_early", message_en, 0);
      send(4'd2, 256'hE2);
      in_valid = 1'b0;
      chk("col.en", message_en, 1);
      chk("col.cnt", batch_cnt, 2);
      chk("col.m2", m2, 2);
      chk("col.msg2", message_2, 256'hE2);
      chk("col.m3", m3, 0);
      finish_issue("col", 2'd2);

      // Default control consumed in IDLE
      send(4'd0, 256'hF0);
      in_valid = 1'b0;
      chk("def.err", ctrl_err, 1);
      chk("def.cnt", batch_cnt, 0);
      chk("def.rdy", in_ready, 1);
      chk("def.m1", m1, 0);
      step();
      chk("def.err_clr", ctrl_err, 0);
      chk("def.en", message_en, 0);
      chk("def.cnt2", batch_cnt, 0);

      // Backpressure: valid held through ISSUE
      send(4'd1, 256'h11);
      send(4'd2, 256'h22);
      send(4'd3, 256'h33);
      in_ctrl    = 4'd4;
      in_message = 256'h44;
      chk("bp.en", message_en, 1);
      for (int i = 1; i < HOLD; i++) begin
         step();
         chk("bp.rdy", in_ready, 0);
         chk("bp.cnt", batch_cnt, 3);
         chk("bp.m1", m1, 1);
      end
      step();
      chk("bp.idle_rdy", in_ready, 1);
      chk("bp.idle_cnt", batch_cnt, 0);
      step();
      in_valid = 1'b0;
      chk("bp.load_m1", m1, 4);
      chk("bp.load_msg1", message_1, 256'h44);
      chk("bp.load_cnt", batch_cnt, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_idle("bp.rst");

      // Reset in the 2nd ISSUE cycle
      send(4'd1, 256'h91);
      send(4'd2, 256'h92);
      send(4'd3, 256'h93);
      in_valid = 1'b0;
      step();
      chk("rst.en_mid", message_en, 1);
      rst = 1'b1;
      step();
      chk_idle("rst.hit");
      chk("rst.err", ctrl_err, 0);
      rst = 1'b0;
      for (int i = 0; i < HOLD; i++) begin
         step();
         chk("rst.no_done", batch_done, 0);
         chk("rst.no_en", message_en, 0);
      end
      chk("rst.rdy", in_ready, 1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got hang expected finish");
      $fatal(1, "bench timeout");
   end

endmodule

// File: doc/message_lane_sched.md
MESSAGE_LANE_SCHED -- requirements
Module: message_lane_sched

Interface
REQ-001 SHALL have parameter MSG_W, default 256: message width in bits, equal to the `MAX_MESSAGE_BITS definition.
REQ-002 SHALL have parameter CTRL_W, default 4: lane mux-control width, equal to `message_mux_control_width.
REQ-003 SHALL have parameter MUX_DEFAULT, default 0: lane-empty control code, equal to `message_mux_defaut.
REQ-004 SHALL have parameter TMO, default 8: maximum COLLECT cycles before a partial batch issues; legal range 1..255.
REQ-005 SHALL have parameter HOLD_CYC, default 4: cycles message_en stays high per batch; legal range 1..255.
REQ-006 SHALL have port clk, input, 1 bit: single clock; all logic on the rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port in_valid, input, 1 bit: upstream message valid.
REQ-009 SHALL have port in_ready, output, 1 bit: block accepts a message this cycle.
REQ-010 SHALL have port in_message, input, MSG_W bits: message payload.
REQ-011 SHALL have port in_ctrl, input, CTRL_W bits: mux-control code for the message.
REQ-012 SHALL have port message_en, output, 1 bit: batch enable to the field-extraction stages.
REQ-013 SHALL have ports message_1, message_2 and message_3, outputs, MSG_W bits each: lane payloads.
REQ-014 SHALL have ports message_mux_control_m1, message_mux_control_m2 and message_mux_control_m3, outputs, CTRL_W bits each: lane control codes.
REQ-015 SHALL have port batch_done, output, 1 bit: one-cycle pulse on the last ISSUE cycle.
REQ-016 SHALL have port batch_cnt, output, 2 bits: number of occupied lanes (0..3).
REQ-017 SHALL have port ctrl_err, output, 1 bit: one-cycle pulse when a message with in_ctrl==MUX_DEFAULT is consumed.

Function
REQ-018 SHALL implement FSM states IDLE, COLLECT and ISSUE; all outputs SHALL be registered except in_ready.
REQ-019 SHALL define a transfer as in_valid && in_ready at a rising edge.
REQ-020 SHALL drive in_ready = 1 in IDLE and COLLECT and 0 in ISSUE.
REQ-021 SHALL load each transfer with in_ctrl != MUX_DEFAULT into the lowest empty lane (1, then 2, then 3), setting that lane's message and control outputs on the next cycle, and SHALL increment batch_cnt.
REQ-022 SHALL consume a transfer with in_ctrl == MUX_DEFAULT without loading it, leave batch_cnt and the state unchanged, and pulse ctrl_err for one cycle.
REQ-023 SHALL transition IDLE -> COLLECT on the first loaded transfer and clear the collect timer to 0.
REQ-024 SHALL increment the collect timer by 1 on every cycle spent in COLLECT.
REQ-025 SHALL transition COLLECT -> ISSUE when a loaded transfer fills lane 3.
REQ-026 SHALL transition COLLECT -> ISSUE when the collect timer equals TMO-1, issuing the partial batch.
REQ-027 SHALL, when a transfer coincides with the timeout cycle, load that message and include it in the issued batch.
REQ-028 SHALL drive message_en = 1 for exactly HOLD_CYC consecutive cycles while in ISSUE, with lane payloads and controls held stable throughout.
REQ-029 SHALL assert batch_done in the final ISSUE cycle.
REQ-030 SHALL, on the cycle after ISSUE, be in IDLE with all lane controls equal to MUX_DEFAULT, lane payloads equal to 0, batch_cnt equal to 0 and message_en equal to 0.
REQ-031 SHALL hold empty lanes at control MUX_DEFAULT and payload 0 at all times.
REQ-032 SHALL keep the collect timer and the hold counter at 8 bits each, with no wrap-around within the legal parameter ranges.

Reset
REQ-033 SHALL, when rst is sampled high, enter IDLE and force message_en = 0, batch_done = 0, ctrl_err = 0, batch_cnt = 0, all lane controls to MUX_DEFAULT, all payloads to 0, and both counters to 0.
REQ-034 SHALL treat rst asserted mid-COLLECT or mid-ISSUE as a discard of the batch: no batch_done, and in_ready = 1 on the cycle after rst falls.
REQ-035 SHALL ignore in_valid on any cycle where rst is high, accepting no transfer.

Verification
REQ-036 SHALL pass full batch: 3 back-to-back transfers (ctrl 1, 2, 3) -> lanes m1/m2/m3 = 1/2/3, message_en high for 4 cycles, batch_done on the 4th, then IDLE.
REQ-037 SHALL pass timeout: 1 transfer (ctrl 5), then in_valid low -> ISSUE after 8 COLLECT cycles with batch_cnt = 1, and m2/m3 controls = 0.
REQ-038 SHALL pass timeout collision: 2nd transfer on the timer = 7 cycle -> batch_cnt = 2 in ISSUE.
REQ-039 SHALL pass default control: transfer with ctrl 0 in IDLE -> ctrl_err pulse, state stays IDLE, batch_cnt = 0.
REQ-040 SHALL pass backpressure: in_valid held high during ISSUE -> in_ready = 0 and no load until IDLE, then the message loads into lane 1.
REQ-041 SHALL pass reset mid-ISSUE: rst in the 2nd ISSUE cycle -> all outputs at reset values next cycle and no batch_done.
